// File: rtl/fp_pkg.sv
// Shared types and constants for the fixed-point dot-product engine.
// Holds saturation bounds, accumulator sizing, rounding constant and FSM states.
package fp_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ACCUM,
        DRAIN,
        OUT
    } state_t;

    function automatic int acc_w(input int width, input int max_len);
        return 2 * width + $clog2(max_len + 1) + 1;
    endfunction

    function automatic longint fp_max(input int width);
        return (longint'(1) <<< (width - 1)) - 1;
    endfunction

    function automatic longint fp_min(input int width);
        return -(longint'(1) <<< (width - 1));
    endfunction

    function automatic longint round_const(input int frac);
        return longint'(1) <<< (frac - 1);
    endfunction

endpackage

// File: rtl/fp_dot_acc_if.sv
// Element stream in, result stream out, for fp_dot_acc.
// master drives beats and out_ready; slave is the engine.
interface fp_dot_acc_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_x;
    logic [WIDTH-1:0] in_w;
    logic [WIDTH-1:0] in_bias;
    logic             in_last;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_y;
    logic             out_sat;
    logic             out_len_err;

    modport master (
        output in_valid, in_x, in_w, in_bias, in_last, out_ready,
        input  in_ready, out_valid, out_y, out_sat, out_len_err
    );

    modport slave (
        input  in_valid, in_x, in_w, in_bias, in_last, out_ready,
        output in_ready, out_valid, out_y, out_sat, out_len_err
    );
endinterface

// File: rtl/fp_round_sat.sv
// Accumulator to WIDTH result: round, arithmetic shift, saturate.
// Round-half-up by default; FP_DOT_ACC_RNE_EN selects round-half-to-even.
module fp_round_sat
    import fp_pkg::*;
#(
    parameter int WIDTH    = 32,
    parameter int FRACTION = 16,
    parameter int ACC_W    = 72
) (
    input  logic signed [ACC_W-1:0] acc,
    output logic        [WIDTH-1:0] y,
    output logic                    sat
);
    localparam logic signed [ACC_W-1:0] RC   = ACC_W'(round_const(FRACTION));
    localparam logic signed [ACC_W-1:0] MAXV = ACC_W'(fp_max(WIDTH));
    localparam logic signed [ACC_W-1:0] MINV = ACC_W'(fp_min(WIDTH));

    logic signed [ACC_W-1:0] bump;
    logic signed [ACC_W-1:0] sum;
    logic signed [ACC_W-1:0] q;

`ifdef FP_DOT_ACC_RNE_EN
    // RC-1 plus the kept LSB: a tie carries only when the LSB is odd
    assign bump = RC - ACC_W'(1) + {{(ACC_W-1){1'b0}}, acc[FRACTION]};
`else
    assign bump = RC;
`endif

    assign sum = acc + bump;
    assign q   = sum >>> FRACTION;

    // clamp the shifted value into the WIDTH signed range
    always_comb begin
        y   = q[WIDTH-1:0];
        sat = 1'b0;
        if (q > MAXV) begin
            y   = MAXV[WIDTH-1:0];
            sat = 1'b1;
        end else if (q < MINV) begin
            y   = MINV[WIDTH-1:0];
            sat = 1'b1;
        end
    end
endmodule

// File: rtl/fp_dot_acc.sv
// Streaming saturating fixed-point dot product: y = sum(x*w) + bias.
// Build option FP_DOT_ACC_RNE_EN switches final rounding to half-even.
module fp_dot_acc
    import fp_pkg::*;
#(
    parameter int WIDTH    = 32,
    parameter int FRACTION = 16,
    parameter int MAX_LEN  = 64
) (
    input  logic         clk,
    input  logic         rst_n,
    fp_dot_acc_if.slave  bus
);
    localparam int ACC_W = acc_w(WIDTH, MAX_LEN);
    localparam int CW    = $clog2(MAX_LEN + 2);

    state_t state, state_n;
    logic   drain2;
    logic   rdy_en;
    logic   fire;

    logic [2*WIDTH-1:0]      xe, we, prod;
    logic                    s1_valid;
    logic [2*WIDTH-1:0]      s1_p;
    logic signed [ACC_W-1:0] p_ext, b_ext, b_al, acc;
    logic [CW-1:0]           cnt;

    logic [WIDTH-1:0] y_c, y_q;
    logic             sat_c, sat_q, len_q;

    assign bus.in_ready = rdy_en && (state == IDLE || state == ACCUM);
    assign fire         = bus.in_valid && bus.in_ready;
    assign bus.out_valid   = (state == OUT);
    assign bus.out_y       = y_q;
    assign bus.out_sat     = sat_q;
    assign bus.out_len_err = len_q;

    assign xe    = {{WIDTH{bus.in_x[WIDTH-1]}}, bus.in_x};
    assign we    = {{WIDTH{bus.in_w[WIDTH-1]}}, bus.in_w};
    assign prod  = xe * we;
    assign p_ext = {{(ACC_W-2*WIDTH){s1_p[2*WIDTH-1]}}, s1_p};
    assign b_ext = {{(ACC_W-WIDTH){bus.in_bias[WIDTH-1]}}, bus.in_bias};
    assign b_al  = b_ext <<< FRACTION;

    // next-state decode
    always_comb begin
        state_n = state;
        unique case (state)
            IDLE:  if (fire) state_n = bus.in_last ? DRAIN : ACCUM;
            ACCUM: if (fire && bus.in_last) state_n = DRAIN;
            DRAIN: if (drain2) state_n = OUT;
            OUT:   if (bus.out_ready) state_n = IDLE;
        endcase
    end

    // state, drain phase and ready enable after reset release
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            drain2 <= 1'b0;
            rdy_en <= 1'b0;
        end else begin
            state  <= state_n;
            drain2 <= (state == DRAIN) && !drain2;
            rdy_en <= 1'b1;
        end
    end

    // S1 product, S2 accumulate, beat counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_p     <= '0;
            acc      <= '0;
            cnt      <= '0;
        end else begin
            s1_valid <= fire;
            s1_p     <= prod;
            if (fire && state == IDLE)
                acc <= b_al;
            else if (s1_valid)
                acc <= acc + p_ext;
            if (fire) begin
                if (state == IDLE)
                    cnt <= CW'(1);
                else if (cnt != CW'(MAX_LEN + 1))
                    cnt <= cnt + CW'(1);
            end
        end
    end

    fp_round_sat #(
        .WIDTH    (WIDTH),
        .FRACTION (FRACTION),
        .ACC_W    (ACC_W)
    ) u_rs (
        .acc (acc),
        .y   (y_c),
        .sat (sat_c)
    );

    // S3 result register, loaded once the accumulator has settled
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            y_q   <= '0;
            sat_q <= 1'b0;
            len_q <= 1'b0;
        end else if (state == DRAIN && drain2) begin
            y_q   <= y_c;
            sat_q <= sat_c;
            len_q <= (cnt > CW'(MAX_LEN));
        end
    end
endmodule

// File: doc/fp_dot_acc.md
Name: fp_dot_acc

Overview:
- Streaming saturating fixed-point dot-product engine for the linear-regression core: computes y = sum(x_i * w_i) + bias over a variable-length vector.
- Accepts one (x, w) pair per cycle on a valid/ready stream, accumulates at full product precision, and adds the bias.
- Applies rounding once at the end and saturates to WIDTH bits.
- Replaces chains of combinational add/multiply primitives with one pipelined, back-pressured datapath.

Parameters:
- WIDTH, 32, signed operand/result width (Qm.n, m+n = WIDTH).
- FRACTION, 16, fractional bits n; 1 <= FRACTION <= WIDTH-1.
- MAX_LEN, 64, maximum elements per vector; sets accumulator guard bits.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  element beat valid.
- in_ready  out  1  block can accept a beat.
- in_x  in  WIDTH  signed feature, Qm.n.
- in_w  in  WIDTH  signed weight, Qm.n.
- in_bias  in  WIDTH  signed bias; sampled only on the first beat of a vector.
- in_last  in  1  final beat of vector.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- out_y  out  WIDTH  rounded, saturated result, Qm.n.
- out_sat  out  1  result was clamped.
- out_len_err  out  1  vector had more than MAX_LEN beats.

Behaviour:
- Reset (async assert, sync release): state IDLE; in_ready=0 while rst_n low, 1 from the first cycle after release; out_valid=0, out_y=0, out_sat=0, out_len_err=0; accumulator, count and pipeline valids cleared. Reset mid-vector discards all partial state silently.
- Beat fires when in_valid && in_ready.
- in_ready = 1 in IDLE and ACCUM; 0 in DRAIN and OUT.
- Widths:
  - Product P = x*w is signed 2*WIDTH, Q(2m).(2n).
  - Accumulator ACC_W = 2*WIDTH + $clog2(MAX_LEN+1) + 1, signed, wrap-free for <= MAX_LEN beats.
  - Bias is sign-extended and shifted left by FRACTION before it enters the accumulator.
- Pipeline: S1 registers P; S2 adds P into the accumulator; S3 rounds, shifts right arithmetically by FRACTION, saturates to [-2^(WIDTH-1), 2^(WIDTH-1)-1] and registers out_y/out_sat.
- Latency: out_valid rises exactly 3 cycles after the cycle in which the last beat fires.
- FSM:
  - IDLE: first beat fires -> accumulator loaded with aligned bias, count=1, go ACCUM (or DRAIN if in_last also set).
  - ACCUM: each beat increments count (saturating at MAX_LEN+1); beat with in_last -> DRAIN.
  - DRAIN: 2 cycles flushing S1/S2, then OUT.
  - OUT: out_valid=1; out_y, out_sat, out_len_err held stable until out_valid && out_ready -> IDLE, with in_ready=1 the next cycle.
- Single-beat vector (first beat also last) is legal: y = x*w + bias.
- out_len_err=1 when count exceeds MAX_LEN. Accumulation continues; the result is undefined but still saturated and still delivered.
- Default rounding is round-half-up: add 2^(FRACTION-1), then arithmetic shift; ties go toward +inf for both signs.
- in_x/in_w/in_bias are don't-care when the beat does not fire. in_last without in_valid is ignored.

Optional Feature:
- Macro FP_DOT_ACC_RNE_EN.
- Defined: round-half-to-even at S3. Ties (discarded bits == exactly 2^(FRACTION-1)) round to the even LSB; non-ties are identical to default.
- Undefined: round-half-up as above.
- Latency and interface are identical in both builds.

Decomposition:
- Shared package fp_pkg: FP_MAX/FP_MIN functions of WIDTH, ACC_W computation, rounding-constant function, FSM state encoding (IDLE, ACCUM, DRAIN, OUT).
- One sub-module: fp_round_sat. Combinational ACC_W -> WIDTH round, shift and saturate, with rounding mode selected by the macro; instantiated in S3 and unit-testable alone.

Test Plan:
- Single beat: x=0x00020000, w=0x00018000, bias=0x00004000, last=1 -> out_y=0x00034000, out_sat=0, out_valid 3 cycles after fire.
- Three beats: x={1.0,2.0,3.0}, w=1.0 each, bias=0 -> out_y=0x00060000. Also hold in_valid low one cycle mid-vector -> same result.
- Saturation: x=0x7FFF0000, w=0x00020000, 2 beats -> out_y=0x7FFFFFFF, out_sat=1. x=0xFFFF0000, w=0x7FFF0000, 3 beats -> out_y=0x80000000, out_sat=1.
- Rounding tie: x=0x00000001, w=0x00008000, bias=0 -> out_y=0x00000001 by default; out_y=0x00000000 with FP_DOT_ACC_RNE_EN.
- Back-pressure: out_ready low 5 cycles -> out_y stable and in_ready=0 throughout; on fire, in_ready=1 next cycle. Next vector is accepted with its own bias.
- Length/reset: MAX_LEN=4, 5 beats -> out_len_err=1. Assert rst_n low mid-vector -> outputs 0 immediately; a following vector produces the correct result.
